run_length_word_tracker: RTL
============================

// Module: run_length_word_tracker
// PURPOSE
//  Parametrised successor to the same-consecutive-word counter. Samples a word stream on enable.
//  Compares each word to the previous one under a bit mask, and maintains these statistics:
//    - a saturating count of matching consecutive pairs
//    - the current run length
//    - the longest run and the word that formed it
//  On every completed run, pushes a {run_word, run_len} record into a FIFO drained by a valid/ready handshake.
// PARAMETERS
//  WORD_W     8            width of the input word
//  CNT_W      10           width of the matching-pair counter (saturates at 2^CNT_W-1)
//  RUN_W      8            width of run-length fields (saturates at 2^RUN_W-1)
//  MATCH_MASK {WORD_W{1}}  only bits set here take part in the compare
//  DEPTH      4            record FIFO depth (power of two, >=2)
// PORTS
//  clk                 in   1      rising-edge clock
//  reset_n             in   1      asynchronous active-low reset
//  clear               in   1      sync clear of all state, counters, FIFO and sticky flag
//  enable              in   1      sample word this cycle
//  word                in   WORD_W input word
//  flush               in   1      close the current run now (push its record)
//  num_same_cons_words out  CNT_W  matching consecutive pairs since reset/clear
//  run_len             out  RUN_W  length of current run (0 = no word since reset/clear/flush)
//  max_run_len         out  RUN_W  longest completed-or-current run
//  max_run_word        out  WORD_W first word of that run
//  rec_valid           out  1      FIFO not empty
//  rec_ready           in   1      consumer accepts head record
//  rec_word            out  WORD_W head record: first word of the run
//  rec_len             out  RUN_W  head record: run length (>=1)
//  rec_overflow        out  1      sticky: a record was dropped because the FIFO was full
// BEHAVIOUR
//  Reset values (reset_n=0, async)
//  - All outputs 0; FIFO empty; have_prev=0; prev_word=0.
//  - clear=1 at a clock edge: same result, synchronously. clear has priority over enable, flush and rec pop.
//  Match rule
//  - match = have_prev && (((word ^ prev_word) & MATCH_MASK) == 0).
//  - prev_word is loaded on every enabled sample, not only on a match.
//  Per enabled sample
//  - match: num_same_cons_words +1 (saturating); run_len +1 (saturating).
//  - no match, have_prev=1: push {run_start_word, run_len}; run_start_word=word; run_len=1.
//  - have_prev=0: run_start_word=word; run_len=1; no push; have_prev becomes 1.
//  flush
//  - flush=1 and run_len!=0: push the current run, then run_len=0 and have_prev=0.
//  - flush with run_len==0: no-op.
//  - flush && enable in the same cycle: the current run is pushed, and the incoming word starts a new run (run_len=1, have_prev=1).
//  - The incoming word is never compared against the flushed run.
//  max tracking
//  - If the updated run_len > max_run_len, then max_run_len=run_len and max_run_word=run_start_word.
//  - Ties keep the older run.
//  FIFO
//  - Pop occurs on rec_valid && rec_ready.
//  - A pushed record is visible on rec_* the cycle after its push edge; rec_* are stable while rec_valid && !rec_ready.
//  - Push and pop in the same cycle while full: both succeed; no drop.
//  - Push while full without pop: record discarded, rec_overflow=1 until reset/clear.
//  - Pop while empty is ignored.
//  Timing and saturation
//  - All statistics are registered: the sample at edge N is reflected after edge N (1-cycle latency).
//  - Counters hold at all-ones; no wrap.
//  - enable=0: statistics do not change; flush and FIFO pops still act.
// TESTING
//  1 reset_n low mid-stream with FIFO holding 2 records -> all outputs 0 immediately (before next edge), rec_valid=0.
//  2 WORD_W=8: enable words 05,05,05,07,07 -> num_same=3, run_len=2, max_run_len=3, max_run_word=05; one record {05,3}.
//  3 MATCH_MASK=8'h0F: words 15,25,35 -> num_same=2, run_len=3, no record pushed.
//  4 DEPTH=4, rec_ready=0: 6 alternating words 01,02,01,02,01,02 -> 5 runs closed, 4 records held, rec_overflow=1; raise rec_ready -> {01,1},{02,1},{01,1},{02,1} in order.
//  5 CNT_W=3: 10 identical words -> num_same=7 held; RUN_W=3 -> run_len=7 held.
//  6 flush+enable same edge with run {09,4} open and word 09 -> record {09,4}; run_len=1; num_same unchanged.

Source files
------------

// File: rtl/run_length_word_tracker.sv
// rtl/run_length_word_tracker.sv - masked consecutive-word run tracker with run record FIFO
module run_length_word_tracker #(
  parameter int                WORD_W     = 8,
  parameter int                CNT_W      = 10,
  parameter int                RUN_W      = 8,
  parameter logic [WORD_W-1:0] MATCH_MASK = {WORD_W{1'b1}},
  parameter int                DEPTH      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [WORD_W-1:0] word,
  input  logic              flush,
  output logic [CNT_W-1:0]  num_same_cons_words,
  output logic [RUN_W-1:0]  run_len,
  output logic [RUN_W-1:0]  max_run_len,
  output logic [WORD_W-1:0] max_run_word,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [WORD_W-1:0] rec_word,
  output logic [RUN_W-1:0]  rec_len,
  output logic              rec_overflow
);

  localparam int AW = $clog2(DEPTH);

  // Run tracking state
  logic              have_prev;
  logic [WORD_W-1:0] prev_word;
  logic [WORD_W-1:0] run_start_word;

  // Next-state values
  logic              have_prev_d;
  logic [WORD_W-1:0] prev_word_d;
  logic [WORD_W-1:0] run_start_word_d;
  logic [RUN_W-1:0]  run_len_d;
  logic [CNT_W-1:0]  num_same_d;
  logic [RUN_W-1:0]  max_run_len_d;
  logic [WORD_W-1:0] max_run_word_d;
  logic              match;
  logic              push;

  // FIFO state; pointers carry one extra wrap bit to tell full from empty
  logic [WORD_W-1:0] mem_word [DEPTH];
  logic [RUN_W-1:0]  mem_len  [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push_ok;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && rec_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok    = push && (!fifo_full || pop);

  assign rec_valid = !fifo_empty;
  assign rec_word  = fifo_empty ? '0 : mem_word[rd_ptr[AW-1:0]];
  assign rec_len   = fifo_empty ? '0 : mem_len[rd_ptr[AW-1:0]];

  // Next run statistics: flush closes the run first so a same-cycle word never matches it
  always_comb begin
    have_prev_d      = have_prev;
    prev_word_d      = prev_word;
    run_start_word_d = run_start_word;
    run_len_d        = run_len;
    num_same_d       = num_same_cons_words;
    max_run_len_d    = max_run_len;
    max_run_word_d   = max_run_word;
    match            = 1'b0;
    push             = 1'b0;

    if (flush && (run_len != '0)) begin
      push        = 1'b1;
      run_len_d   = '0;
      have_prev_d = 1'b0;
    end

    if (enable) begin
      match = have_prev_d && (((word ^ prev_word) & MATCH_MASK) == '0);
      if (match) begin
        if (num_same_cons_words != '1) num_same_d = num_same_cons_words + 1'b1;
        if (run_len != '1) run_len_d = run_len + 1'b1;
      end else begin
        if (have_prev_d) push = 1'b1;
        run_start_word_d = word;
        run_len_d        = RUN_W'(1);
        have_prev_d      = 1'b1;
      end
      prev_word_d = word;
      // Strictly greater, so a tie leaves the older run as the maximum
      if (run_len_d > max_run_len) begin
        max_run_len_d  = run_len_d;
        max_run_word_d = run_start_word_d;
      end
    end
  end

  // Statistics registers; clear wins over everything else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      have_prev           <= 1'b0;
      prev_word           <= '0;
      run_start_word      <= '0;
      run_len             <= '0;
      num_same_cons_words <= '0;
      max_run_len         <= '0;
      max_run_word        <= '0;
    end else if (clear) begin
      have_prev           <= 1'b0;
      prev_word           <= '0;
      run_start_word      <= '0;
      run_len             <= '0;
      num_same_cons_words <= '0;
      max_run_len         <= '0;
      max_run_word        <= '0;
    end else begin
      have_prev           <= have_prev_d;
      prev_word           <= prev_word_d;
      run_start_word      <= run_start_word_d;
      run_len             <= run_len_d;
      num_same_cons_words <= num_same_d;
      max_run_len         <= max_run_len_d;
      max_run_word        <= max_run_word_d;
    end
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rec_overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rec_overflow <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push && !push_ok) rec_overflow <= 1'b1;
    end
  end

  // Record storage; contents are masked by the pointers so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem_word[wr_ptr[AW-1:0]] <= run_start_word;
      mem_len[wr_ptr[AW-1:0]]  <= run_len;
    end
  end

endmodule
